// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the ram_dp_sync slice.
//   state_e      - clear sequencer states (ST_INIT sweeping, ST_READY serving)
//   DEF_*        - default configuration (16-bit words, 16 entries, 8-bit lanes)
//   NB, DEPTH    - lane count and word count of the default configuration
//   lane_parity  - even-parity bit of one byte lane (zero-extended to MAX_LANE_W)
// Optional feature macro used by the slice: RAM_PARITY_EN.
package ram_pkg;

    typedef enum logic {ST_INIT, ST_READY} state_e;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_BYTE_W = 8;
    localparam int unsigned NB         = DEF_DATA_W / DEF_BYTE_W;
    localparam int unsigned DEPTH      = 2 ** DEF_ADDR_W;
    localparam int unsigned MAX_LANE_W = 64;

    // Zero-extension does not change the XOR, so one function serves any lane width.
    function automatic logic lane_parity(input logic [MAX_LANE_W-1:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/ram_dp_sync_if.sv
// ram_dp_sync_if: write and read port bundle of ram_dp_sync.
//   wr_en/wr_addr/wr_data/wr_be : write port with per-lane byte enables
//   rd_en/rd_addr               : read request
//   rd_data/rd_valid/rd_perr    : registered read response
// Modports: master (load/store side, drives requests), slave (the RAM).
interface ram_dp_sync_if
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned BYTE_W = DEF_BYTE_W
);
    localparam int unsigned NB = DATA_W / BYTE_W;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NB-1:0]     wr_be;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_perr;

    modport master (output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
                    input  rd_data, rd_valid, rd_perr);
    modport slave  (input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
                    output rd_data, rd_valid, rd_perr);
endinterface

// File: rtl/ram_clear_fsm.sv
// ram_clear_fsm: sweeps zeros through the array after reset or a clr pulse.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : re-zero request, honoured only in ST_READY
//   init_busy   : high while sweeping (ST_INIT)
//   clr_we      : array write strobe for the sweep
//   clr_addr    : address being zeroed this cycle
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              init_busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    localparam logic [ADDR_W-1:0] LAST = '1;

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        init_busy = 1'b0;
        clr_we    = 1'b0;
        clr_addr  = cnt;
        case (state)
            ST_INIT: begin
                init_busy = 1'b1;
                clr_we    = 1'b1;
                // Counter parks on the last address; it is re-zeroed on the next clr.
                if (cnt == LAST) state_nxt = ST_READY;
                else             cnt_nxt   = cnt + 1'b1;
            end
            ST_READY: begin
                if (clr) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end
endmodule

// File: rtl/ram_dp_sync.sv
// ram_dp_sync: simple-dual-port synchronous RAM with byte enables,
// registered write-first read and a built-in clear sweep.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : single-cycle request to re-zero the array
//   init_busy  : high during the clear sweep; port traffic is ignored
//   bus        : ram_dp_sync_if.slave (write port, read port, read response)
// Optional: define RAM_PARITY_EN for per-lane even parity and rd_perr.
module ram_dp_sync
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned BYTE_W = DEF_BYTE_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          init_busy,
    ram_dp_sync_if.slave  bus
);
    localparam int unsigned NB    = DATA_W / BYTE_W;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    if ((DATA_W % BYTE_W) != 0) begin : g_bad_cfg
        $error("ram_dp_sync: DATA_W must be a multiple of BYTE_W");
    end

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    ram_clear_fsm #(.ADDR_W(ADDR_W)) u_clr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] lane_mask, wr_merged;
    logic              wr_ok, rd_ok, byp, rd_err;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q, rd_perr_q;

    // clr wins over a same-cycle write; a same-cycle read still completes.
    assign wr_ok = bus.wr_en & ~init_busy & ~clr;
    assign rd_ok = bus.rd_en & ~init_busy;
    assign byp   = wr_ok & bus.rd_en & (bus.wr_addr == bus.rd_addr);

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] wr_par_new, wr_par_merged, rd_par_calc;
`endif

    for (genvar g = 0; g < NB; g++) begin : g_lane
        assign lane_mask[g*BYTE_W +: BYTE_W] = {BYTE_W{bus.wr_be[g]}};
`ifdef RAM_PARITY_EN
        assign wr_par_new[g]  = lane_parity(MAX_LANE_W'(bus.wr_data[g*BYTE_W +: BYTE_W]));
        assign rd_par_calc[g] = lane_parity(MAX_LANE_W'(mem[bus.rd_addr][g*BYTE_W +: BYTE_W]));
`endif
    end

    // Merged word serves both the array write and the write-first bypass.
    assign wr_merged = (mem[bus.wr_addr] & ~lane_mask) | (bus.wr_data & lane_mask);

    always_ff @(posedge clk) begin
        if (clr_we)     mem[clr_addr]    <= '0;
        else if (wr_ok) mem[bus.wr_addr] <= wr_merged;
    end

`ifdef RAM_PARITY_EN
    // Disabled lanes keep their stored parity bit, even a bad one.
    assign wr_par_merged = (par_mem[bus.wr_addr] & ~bus.wr_be) | (wr_par_new & bus.wr_be);

    always_ff @(posedge clk) begin
        if (clr_we)     par_mem[clr_addr]    <= '0;
        else if (wr_ok) par_mem[bus.wr_addr] <= wr_par_merged;
    end

    // Bypassed data carries fresh parity, so it cannot be in error.
    assign rd_err = ~byp & (rd_par_calc != par_mem[bus.rd_addr]);
`else
    assign rd_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_perr_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_ok;
            rd_perr_q  <= rd_ok & rd_err;
            if (rd_ok) rd_data_q <= byp ? wr_merged : mem[bus.rd_addr];
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_perr  = rd_perr_q;
endmodule

// File: tb/tb_ram_dp_sync.sv
// tb_ram_dp_sync: randomized + directed bench for ram_dp_sync with a
// word-level reference model and a scoreboard queue drained by a monitor.
module tb_ram_dp_sync;
    import ram_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int BW = 8;
    localparam int D  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic init_busy;

    ram_dp_sync_if #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(BW)) bus ();

    ram_dp_sync #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .init_busy (init_busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          perr;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] ref_mem [D];
    logic [1:0]    corrupt [D];
    logic [DW-1:0] last_data = '0;
    int            busy_left = 0;
    int            errors = 0;
    int            checks = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    task automatic model_zero();
        for (int i = 0; i < D; i++) begin
            ref_mem[i] = '0;
            corrupt[i] = '0;
        end
    endtask

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [1:0] be, input logic re, input logic [AW-1:0] ra,
                        input logic c);
        logic bypass;
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd; bus.wr_be = be;
        bus.rd_en = re; bus.rd_addr = ra; clr = c;
        chk("init_busy", 32'(init_busy), 32'(busy_left > 0));
        @(posedge clk);
        if (busy_left > 0) begin
            busy_left--;
        end else begin
            bypass = we && re && !c && (wa == ra);
            if (we && !c) begin
                for (int l = 0; l < 2; l++)
                    if (be[l]) ref_mem[wa][l*BW +: BW] = wd[l*BW +: BW];
                corrupt[wa] = corrupt[wa] & ~be;
            end
            if (re) begin
                q.push_back('{d: ref_mem[ra], perr: !bypass && (corrupt[ra] != 2'b00)});
                last_data = ref_mem[ra];
            end
            if (c) begin
                busy_left = D;
                model_zero();
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 2'b00, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, '0, '0, 2'b00, 1'b1, a, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        step(1'b1, a, d, be, 1'b0, '0, 1'b0);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must drop without a clock.
    task automatic async_reset();
        rst_n = 1'b0;
        q.delete();
        last_data = '0;
        model_zero();
        busy_left = D;
        #1;
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
        chk("rst_rd_perr", 32'(bus.rd_perr), 32'h0);
        chk("rst_init_busy", 32'(init_busy), 32'h1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every response must match the head of the queue exactly one
    // cycle after its request; idle cycles must hold rd_data and keep rd_perr low.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rd_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rd_valid", 32'(bus.rd_valid), 32'h0);
            end else begin
                e = q.pop_front();
                chk("rd_data", 32'(bus.rd_data), 32'(e.d));
                chk("rd_perr", 32'(bus.rd_perr), 32'(e.perr));
            end
        end else begin
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("missing_rd_valid", 32'(bus.rd_valid), 32'h1);
            end
            chk("rd_data_hold", 32'(bus.rd_data), 32'(last_data));
            chk("rd_perr_idle", 32'(bus.rd_perr), 32'h0);
        end
    end

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        model_zero();

        // Reset state
        @(posedge clk);
        #1;
        chk("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("reset_rd_data", 32'(bus.rd_data), 32'h0);
        chk("reset_init_busy", 32'(init_busy), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        busy_left = D;

        // Power-up sweep, then every address reads zero
        repeat (D) idle();
        for (int i = 0; i < D; i++) rd(AW'(i));

        // Byte enables
        wr(4'd3, 16'hABCD, 2'b11);
        wr(4'd3, 16'h1234, 2'b01);
        rd(4'd3);
        wr(4'd4, 16'hBEEF, 2'b00);
        rd(4'd4);

        // Write-first bypass with a partial lane update
        wr(4'd5, 16'h1111, 2'b11);
        step(1'b1, 4'd5, 16'h2222, 2'b10, 1'b1, 4'd5, 1'b0);

        // clr drops the same-cycle write, keeps the same-cycle read, and
        // ignores all traffic during the sweep
        wr(4'd7, 16'h7777, 2'b11);
        step(1'b1, 4'd7, 16'hFFFF, 2'b11, 1'b1, 4'd7, 1'b0);
        step(1'b1, 4'd7, 16'hFFFF, 2'b11, 1'b1, 4'd7, 1'b1);
        for (int i = 0; i < D; i++)
            step(1'b1, AW'(i), 16'hC3C3, 2'b11, 1'b1, AW'(i), (i == 3));
        rd(4'd7);
        rd(4'd0);

        // Reset in the middle of a sweep, with rd_data holding a non-zero word
        wr(4'd9, 16'h5A5A, 2'b11);
        rd(4'd9);
        step(1'b0, '0, '0, 2'b00, 1'b0, '0, 1'b1);
        repeat (8) idle();
        async_reset();
        repeat (D) idle();
        rd(4'd9);

`ifdef RAM_PARITY_EN
        // Corrupt the stored lane-0 parity of addr 2
        begin
            logic [1:0] p;
            wr(4'd2, 16'h00FF, 2'b11);
            idle();
            p = dut.par_mem[2] ^ 2'b01;
            force dut.par_mem[2] = p;
            corrupt[2] = 2'b01;
            rd(4'd2);
            release dut.par_mem[2];
            step(1'b1, 4'd2, 16'h3300, 2'b10, 1'b1, 4'd2, 1'b0);
            rd(4'd2);
            wr(4'd2, 16'h0001, 2'b01);
            rd(4'd2);
        end
`endif

        // Randomized traffic on a narrow address range to hit bypass often
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 5)), 16'($urandom),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 5)), ($urandom_range(0, 59) == 0));
        end
        repeat (D + 2) idle();

        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ram_dp_sync.md
# ram_dp_sync

Parametrised simple-dual-port synchronous RAM, the next generation of the CPU's 16x16 data memory. One write port with per-byte enables, one independent read port with a registered read and a valid strobe, and a built-in clear sequencer that zeroes the array after reset or on request. It sits between the datapath load/store unit and the register-file writeback path. Reads return data one cycle after the request, with write-first bypass.

## Interface
- DATA_W, 16: word width in bits; must be a multiple of BYTE_W, otherwise elaboration fails.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W words.
- BYTE_W, 8: byte-lane width; NB = DATA_W/BYTE_W lanes.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  single-cycle request to re-zero the whole array.
- init_busy  out  1  high while the clear sweep runs; ports ignored.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  NB  byte-lane enables; lane i covers bits [i*BYTE_W +: BYTE_W].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data, registered.
- rd_valid  out  1  one-cycle strobe; rd_data valid.
- rd_perr  out  1  parity error on the current read, qualified by rd_valid.

## Operation
- The FSM has two states, ST_INIT and ST_READY.
- Reset asserted:
  - state=ST_INIT, clear counter=0, init_busy=1.
  - rd_valid=0, rd_data=0, rd_perr=0.
  - Array contents are not reset directly.
- ST_INIT:
  - Each cycle writes all-zero data (and zero parity) to the counter address, then increments the counter.
  - After writing DEPTH-1, the FSM moves to ST_READY and init_busy drops.
  - wr_en, rd_en and clr are ignored; rd_valid stays 0.
- ST_READY:
  - clr=1 returns the FSM to ST_INIT with the counter at 0. clr takes priority over a same-cycle wr_en; that write is dropped.
  - A read issued in the same cycle as clr completes normally.
- Write: with wr_en=1, each lane whose wr_be bit is set is updated at the rising edge. wr_be=0 is a no-op.
- Read:
  - With rd_en=1, rd_data and rd_valid=1 are registered at the edge.
  - With rd_en=0, rd_valid=0 and rd_data holds its last value.
- Bypass: if wr_en && rd_en && wr_addr==rd_addr in the same cycle, rd_data returns the new value. Enabled lanes come from wr_data; disabled lanes come from the old stored word.
- Address wrap: addresses are exactly ADDR_W wide, so there is no out-of-range case. The clear counter stops at DEPTH-1 and does not wrap.

## Timing
- Read latency: 1 cycle, request edge to data. Throughput is one read and one write per cycle.
- Clear sweep: init_busy is high for exactly DEPTH rising edges after rst_n deasserts, or after the edge that samples clr. The first usable cycle is edge DEPTH+1.
- Reset asserted mid-sweep or mid-read: outputs go to reset values immediately, without waiting for a clock, and the sweep restarts from 0 after release.
- rd_perr is registered in the same cycle as rd_valid. It is 0 whenever rd_valid=0.

## Configuration
- RAM_PARITY_EN defined:
  - One even-parity bit per byte lane is stored alongside the data and written per lane with wr_be.
  - On a read, rd_perr=1 if any lane's recomputed parity mismatches its stored bit.
  - Bypassed reads use freshly computed parity and never flag an error.
- RAM_PARITY_EN undefined: no parity storage; rd_perr is tied to 0. The port list is unchanged.

## Structure
- Package ram_pkg holds:
  - the state enum (ST_INIT, ST_READY);
  - the lane-parity function;
  - localparam helpers NB and DEPTH.
- Sub-module ram_clear_fsm holds the state, counter and init_busy. It outputs clear address and clear write-enable into the array mux.
- Storage, byte-lane write and the read/bypass register stay in ram_dp_sync.

## Test plan
- Reset clear (defaults): release rst_n.
  - init_busy is high for 16 cycles.
  - Then rd_en on all 16 addresses returns 0x0000 with rd_valid one cycle later.
- Byte enables:
  - Write 0xABCD to addr 3 with wr_be=2'b11.
  - Then write 0x1234 with wr_be=2'b01.
  - Read addr 3 -> 0xAB34.
- Bypass: addr 5 holds 0x1111. In the same cycle, write 0x2222 with wr_be=2'b10 and read addr 5 -> rd_data=0x2211.
- Clear and ignored traffic:
  - Pulse clr with wr_en=1 to addr 7 (data 0xFFFF).
  - init_busy is high for 16 cycles.
  - A read issued during the sweep gives rd_valid=0.
  - After the sweep, addr 7 reads 0x0000.
- Reset mid-sweep: assert rst_n=0 at sweep cycle 8.
  - rd_valid and rd_data go to 0 asynchronously.
  - After release, init_busy lasts a full 16 cycles.
- Parity (RAM_PARITY_EN):
  - Write 0x00FF to addr 2, then force-flip the stored lane-0 parity bit.
  - Read addr 2 -> rd_perr=1 with rd_valid=1.
  - A bypassed read of addr 2 -> rd_perr=0.
